imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension stage for the Tron datapath. It decodes the 8-bit instruction opcode and widens the instruction immediate to DATA_WIDTH. Modes are sign-extend, zero-extend, shift-amount extend and load-upper. Results are buffered in a 2-entry valid/ready output queue, so decode can stall or run ahead of the register-read/ALU stage without losing operands.

Parameters:
DATA_WIDTH, 16, width of extended immediate; must be >= 2*IMM_WIDTH
IMM_WIDTH, 8, width of raw instruction immediate field
SHAMT_WIDTH, 4, width of shift-amount field for LSHI forms; must be < IMM_WIDTH

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all buffered entries (branch mispredict / redirect)
in_valid  in  1  upstream offers op/imm this cycle
in_ready  out  1  stage can accept; equals (count < 2)
in_op  in  8  instruction opcode byte
in_imm  in  IMM_WIDTH  raw immediate
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head this cycle
out_imm  out  DATA_WIDTH  extended immediate of head entry
out_kind  out  2  extension applied: 0 zero, 1 sign, 2 shamt, 3 upper

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n, clk).
- Reset values: count=0, out_valid=0, out_imm=0, out_kind=0, both buffer entries zeroed. in_ready=1 (count=0). Pushes are ignored while reset_n is low.
- Decode (combinational, on input side):
  - sign (kind 1): ADDI 0x50, SUBI 0x90, CMPI 0xB0, BCOND 0xC0, MOVI 0xD0 -> replicate in_imm[IMM_WIDTH-1].
  - shamt (kind 2): LSHI0 0x80, LSHI1 0x81 -> sign-extend in_imm[SHAMT_WIDTH-1:0]. Upper imm bits are ignored.
  - upper (kind 3): LUI 0xF0 -> {in_imm, IMM_WIDTH zeros}, sign-extended from bit 2*IMM_WIDTH-1 to DATA_WIDTH. At defaults this is in_imm<<8.
  - zero (kind 0): every other opcode, including ANDI 0x10, ORI 0x20, XORI 0x30.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Latency: a push into an empty queue appears on out_imm/out_valid the following cycle. No combinational path exists from in_* to out_*.
- Queue: 2-entry FIFO, head on outputs.
  - Push and pop in the same cycle with count=1: head replaced by new entry, count stays 1.
  - Push and pop with count=2: cannot occur, because in_ready=0.
  - Pop with count=2: second entry moves to head, in_ready rises next cycle.
  - in_ready depends only on registered count, never on out_ready.
- Order: strictly FIFO; no reordering.
- flush: next cycle count=0, out_valid=0. flush overrides a simultaneous push, which is dropped. A pop in the flush cycle is still a valid transfer for downstream.
- Reset mid-operation: all entries discarded immediately (async). out_valid falls without waiting for a clock edge.
- out_imm/out_kind hold their last value when out_valid=0. Downstream must not sample them then.

Decomposition:
- Shared package tron_isa_pkg holds:
  - opcode localparams (ADDI, SUBI, CMPI, ANDI, ORI, XORI, LSHI0, LSHI1, BCOND, MOVI, LUI);
  - the 2-bit ext_kind encoding constants.
- Sub-module imm_ext_decode: purely combinational op/imm -> {kind, extended value}, parametrised by the same three widths. imm_extend_pipe instantiates it and adds the queue/handshake logic.

Test Plan:
- Reset then push ADDI imm=0xF6, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFF6, kind=1. Following cycle out_valid=0.
- Push LSHI1 imm=0x0D, then ANDI imm=0xF6 back-to-back, out_ready=1 -> out_imm=0xFFFD kind=2, then 0x00F6 kind=0, on consecutive cycles.
- out_ready=0; push LUI 0x12, SUBI 0x80, then attempt CMPI 0x01 -> in_ready=0 after two pushes and the third is not accepted. Raise out_ready -> 0x1200 kind=3, then 0xFF80 kind=1. in_ready=1 one cycle after the first pop.
- count=1 with head 0x0005; simultaneous push BCOND 0xFE and pop -> next cycle head=0xFFFE, count stays 1, no bubble.
- count=2, assert flush together with in_valid (MOVI 0x7F) -> next cycle out_valid=0, in_ready=1, and MOVI never appears.
- Drop reset_n asynchronously mid-cycle with count=2 -> out_valid=0 and out_imm=0 before the next clk edge. After release, the first push behaves as in scenario 1.

Source files
------------

// File: rtl/tron_isa_pkg.sv
// rtl/tron_isa_pkg.sv - Tron ISA opcodes and immediate-extension kind encoding
// Purpose: shared opcode byte values and the 2-bit ext_kind codes used by the
//          immediate decode and the extension pipeline stage.
// Ports:   none (package).
package tron_isa_pkg;

    localparam logic [7:0] OP_ANDI  = 8'h10;
    localparam logic [7:0] OP_ORI   = 8'h20;
    localparam logic [7:0] OP_XORI  = 8'h30;
    localparam logic [7:0] OP_ADDI  = 8'h50;
    localparam logic [7:0] OP_LSHI0 = 8'h80;
    localparam logic [7:0] OP_LSHI1 = 8'h81;
    localparam logic [7:0] OP_SUBI  = 8'h90;
    localparam logic [7:0] OP_CMPI  = 8'hB0;
    localparam logic [7:0] OP_BCOND = 8'hC0;
    localparam logic [7:0] OP_MOVI  = 8'hD0;
    localparam logic [7:0] OP_LUI   = 8'hF0;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'd0,
        EXT_SIGN  = 2'd1,
        EXT_SHAMT = 2'd2,
        EXT_UPPER = 2'd3
    } ext_kind_t;

endpackage

// File: rtl/imm_ext_decode.sv
// rtl/imm_ext_decode.sv - combinational opcode decode and immediate widening
// Purpose: selects the extension kind from the opcode and produces the
//          DATA_WIDTH immediate. Purely combinational.
// Ports:   i_op   - instruction opcode byte
//          i_imm  - raw IMM_WIDTH immediate
//          o_kind - extension applied (0 zero, 1 sign, 2 shamt, 3 upper)
//          o_imm  - extended immediate
module imm_ext_decode
    import tron_isa_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IMM_WIDTH   = 8,
    parameter int SHAMT_WIDTH = 4
) (
    input  logic [7:0]            i_op,
    input  logic [IMM_WIDTH-1:0]  i_imm,
    output logic [1:0]            o_kind,
    output logic [DATA_WIDTH-1:0] o_imm
);

    logic [DATA_WIDTH-1:0] w_zext;
    logic [DATA_WIDTH-1:0] w_sext;
    logic [DATA_WIDTH-1:0] w_shamt;
    logic [DATA_WIDTH-1:0] w_upper;

    assign w_zext  = DATA_WIDTH'(i_imm);
    assign w_sext  = DATA_WIDTH'($signed(i_imm));
    assign w_shamt = DATA_WIDTH'($signed(i_imm[SHAMT_WIDTH-1:0]));
    // Shifting the sign-extended immediate gives {imm, zeros} sign-extended
    // from bit 2*IMM_WIDTH-1, without a zero-width replication when
    // DATA_WIDTH == 2*IMM_WIDTH.
    assign w_upper = w_sext << IMM_WIDTH;

    always_comb begin
        o_kind = EXT_ZERO;
        o_imm  = w_zext;
        case (i_op)
            OP_ADDI, OP_SUBI, OP_CMPI, OP_BCOND, OP_MOVI: begin
                o_kind = EXT_SIGN;
                o_imm  = w_sext;
            end
            OP_LSHI0, OP_LSHI1: begin
                o_kind = EXT_SHAMT;
                o_imm  = w_shamt;
            end
            OP_LUI: begin
                o_kind = EXT_UPPER;
                o_imm  = w_upper;
            end
            default: begin
                o_kind = EXT_ZERO;
                o_imm  = w_zext;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extension with 2-entry output queue
// Purpose: decodes op/imm and buffers the extended result in a 2-entry FIFO
//          with valid/ready handshakes on both sides.
// Ports:   clk, reset_n           - clock, async active-low reset
//          flush                  - synchronous clear of buffered entries
//          in_valid/in_ready      - upstream handshake (in_ready = count < 2)
//          in_op, in_imm          - opcode byte and raw immediate
//          out_valid/out_ready    - downstream handshake for the head entry
//          out_imm, out_kind      - head entry extended immediate and kind
module imm_extend_pipe
    import tron_isa_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IMM_WIDTH   = 8,
    parameter int SHAMT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_op,
    input  logic [IMM_WIDTH-1:0]  in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [1:0]            out_kind
);

    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_imm0;
    logic [1:0]            r_kind0;
    logic [DATA_WIDTH-1:0] r_imm1;
    logic [1:0]            r_kind1;

    logic [DATA_WIDTH-1:0] w_dec_imm;
    logic [1:0]            w_dec_kind;
    logic                  w_push;
    logic                  w_pop;

    imm_ext_decode #(
        .DATA_WIDTH  (DATA_WIDTH),
        .IMM_WIDTH   (IMM_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_decode (
        .i_op   (in_op),
        .i_imm  (in_imm),
        .o_kind (w_dec_kind),
        .o_imm  (w_dec_imm)
    );

    // Both handshake outputs come straight from the registered count, so
    // there is no combinational path from in_* or out_ready to them.
    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_imm   = r_imm0;
    assign out_kind  = r_kind0;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_imm0  <= '0;
            r_kind0 <= 2'd0;
            r_imm1  <= '0;
            r_kind1 <= 2'd0;
        end else if (flush) begin
            // Entry data is left in place so the outputs hold their last value.
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_imm0  <= w_dec_imm;
                        r_kind0 <= w_dec_kind;
                    end else begin
                        r_imm1  <= w_dec_imm;
                        r_kind1 <= w_dec_kind;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_imm0  <= r_imm1;
                        r_kind0 <= r_kind1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with count == 1: head is replaced in place.
                    r_imm0  <= w_dec_imm;
                    r_kind0 <= w_dec_kind;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [7:0]  in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_kind;

    int checks;
    int errors;

    imm_extend_pipe #(
        .DATA_WIDTH  (16),
        .IMM_WIDTH   (8),
        .SHAMT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_kind  (out_kind)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] imm);
        in_valid = v;
        in_op    = op;
        in_imm   = imm;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 16'h0000 || out_kind !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b imm=%h kind=%0d, expected 0 1 0000 0",
                     out_valid, in_ready, out_imm, out_kind);
        end
    endtask

    task automatic test_single_addi(input string tag);
        out_ready = 1'b1;
        drive(1'b1, 8'h50, 8'hF6);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'hFFF6 || out_kind !== 2'd1) begin
            errors++;
            $display("FAIL %s_addi: valid=%b imm=%h kind=%0d, expected 1 fff6 1", tag, out_valid, out_imm, out_kind);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: valid=%b, expected 0", tag, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(1'b1, 8'h81, 8'h0D);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'hFFFD || out_kind !== 2'd2) begin
            errors++;
            $display("FAIL b2b_lshi1: valid=%b imm=%h kind=%0d, expected 1 fffd 2", out_valid, out_imm, out_kind);
        end
        drive(1'b1, 8'h10, 8'hF6);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'h00F6 || out_kind !== 2'd0) begin
            errors++;
            $display("FAIL b2b_andi: valid=%b imm=%h kind=%0d, expected 1 00f6 0", out_valid, out_imm, out_kind);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_full_stall;
        out_ready = 1'b0;
        drive(1'b1, 8'hF0, 8'h12);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready_one: in_ready=%b, expected 1", in_ready);
        end
        drive(1'b1, 8'h90, 8'h80);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_full: in_ready=%b, expected 0", in_ready);
        end
        drive(1'b1, 8'hB0, 8'h01);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'h1200 || out_kind !== 2'd3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_head_lui: valid=%b imm=%h kind=%0d ready=%b, expected 1 1200 3 0",
                     out_valid, out_imm, out_kind, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'hFF80 || out_kind !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_head_subi: valid=%b imm=%h kind=%0d ready=%b, expected 1 ff80 1 1",
                     out_valid, out_imm, out_kind, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_third_dropped: valid=%b imm=%h, expected valid 0", out_valid, out_imm);
        end
    endtask

    task automatic test_push_pop_same_cycle;
        out_ready = 1'b0;
        drive(1'b1, 8'h10, 8'h05);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'h0005 || out_kind !== 2'd0) begin
            errors++;
            $display("FAIL pp_head: valid=%b imm=%h kind=%0d, expected 1 0005 0", out_valid, out_imm, out_kind);
        end
        drive(1'b1, 8'hC0, 8'hFE);
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'hFFFE || out_kind !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pp_replace: valid=%b imm=%h kind=%0d ready=%b, expected 1 fffe 1 1",
                     out_valid, out_imm, out_kind, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pp_count_one: valid=%b, expected 0 after single pop", out_valid);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, 8'h20, 8'h01);
        @(negedge clk);
        drive(1'b1, 8'h30, 8'h02);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 8'hD0, 8'h7F);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_movi_dropped: valid=%b imm=%h, expected valid 0", out_valid, out_imm);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(1'b1, 8'h50, 8'h01);
        @(negedge clk);
        drive(1'b1, 8'h50, 8'h02);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_imm !== 16'h0000 || out_kind !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b imm=%h kind=%0d ready=%b, expected 0 0000 0 1",
                     out_valid, out_imm, out_kind, in_ready);
        end
        drive(1'b1, 8'hF0, 8'h33);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_push_ignored: valid=%b imm=%h, expected valid 0", out_valid, out_imm);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_addi("first");
        test_back_to_back();
        test_full_stall();
        test_push_pop_same_cycle();
        test_flush();
        test_async_reset();
        test_single_addi("after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
